// File: rtl/dscope_pkg.sv
// Shared definitions for the data collector: channel geometry and the
// collector state encoding.
package dscope_pkg;

    localparam int NUM_VCHN = 4;
    localparam int VCHN_W   = 2;
    localparam int DATA_W   = 32;
    localparam int LEN_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SWAP    = 2'd2
    } dc_state_e;

endpackage

// File: rtl/dc_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Address layout is {bank, vchn, word}. The array itself has no reset so it
// maps onto block RAM; only the read output register is cleared.
module dc_ram #(
    parameter int DW    = 32,
    parameter int ABITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem_r [0:(1<<ABITS)-1];
    logic [DW-1:0] rdata_r;

    // Sample write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, one cycle of latency, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DW{1'b0}};
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_collector.sv
// Data collector: captures a tagged sample stream into four virtual-channel
// buffers, ping-ponging between a write bank and a read bank at each frame
// end so one frame can be drained while the next is collected.
// Optional build macro DATA_COLLECTOR_STATS_EN adds frame and drop counters.
module data_collector
    import dscope_pkg::*;
#(
    parameter int MAX_LEN = 255,
    parameter int AW      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_start,
    input  logic              i_frame_end,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [VCHN_W-1:0] i_wr_vchn,
    input  logic              i_wr_vld,
    output logic              o_complite,
    input  logic [VCHN_W-1:0] i_rd_vchn,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [LEN_W-1:0]  o_data_len,
    output logic              o_ovf
`ifdef DATA_COLLECTOR_STATS_EN
    ,
    output logic [15:0]       o_frame_cnt,
    output logic [15:0]       o_drop_cnt
`endif
);

    localparam int RAM_AW = 1 + VCHN_W + AW;

    dc_state_e      state_r;
    dc_state_e      state_nxt_s;
    logic           frame_open_s;
    logic           wbank_r;
    logic [LEN_W-1:0] wr_len_r [NUM_VCHN];
    logic [LEN_W-1:0] rd_len_r [NUM_VCHN];
    logic           ovf_frame_r;
    logic           ovf_r;
    logic           pend_r;
    logic           complite_r;
    logic           wr_hit_s;
    logic           room_s;
    logic           we_s;
    logic           drop_s;
    logic [RAM_AW-1:0] waddr_s;
    logic [RAM_AW-1:0] raddr_s;

    // Next-state decode; frame_open_s marks any cycle that (re)opens a frame.
    always_comb begin
        state_nxt_s  = state_r;
        frame_open_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_frame_start) begin
                    state_nxt_s  = COLLECT;
                    frame_open_s = 1'b1;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            COLLECT: begin
                if (i_frame_end) begin
                    state_nxt_s = SWAP;
                end else if (i_frame_start) begin
                    state_nxt_s  = COLLECT;
                    frame_open_s = 1'b1;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            SWAP: begin
                if (pend_r || i_frame_start) begin
                    state_nxt_s  = COLLECT;
                    frame_open_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Write acceptance: a restart discards the word in flight.
    always_comb begin
        wr_hit_s = (state_r == COLLECT) && i_wr_vld && !frame_open_s;
        room_s   = (wr_len_r[i_wr_vchn] < LEN_W'(MAX_LEN));
        we_s     = wr_hit_s && room_s;
        drop_s   = wr_hit_s && !room_s;
        waddr_s  = {wbank_r, i_wr_vchn, AW'(wr_len_r[i_wr_vchn])};
        raddr_s  = {~wbank_r, i_rd_vchn, i_rd_addr};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write lengths and frame overflow flag for the frame being collected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCHN; v++) begin
                wr_len_r[v] <= {LEN_W{1'b0}};
            end
            ovf_frame_r <= 1'b0;
        end else if (frame_open_s) begin
            for (int v = 0; v < NUM_VCHN; v++) begin
                wr_len_r[v] <= {LEN_W{1'b0}};
            end
            ovf_frame_r <= 1'b0;
        end else begin
            if (we_s) begin
                wr_len_r[i_wr_vchn] <= wr_len_r[i_wr_vchn] + 8'd1;
            end
            if (drop_s) begin
                ovf_frame_r <= 1'b1;
            end
        end
    end

    // Bank swap: publish lengths and overflow of the closed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCHN; v++) begin
                rd_len_r[v] <= {LEN_W{1'b0}};
            end
            wbank_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state_r == SWAP) begin
            for (int v = 0; v < NUM_VCHN; v++) begin
                rd_len_r[v] <= wr_len_r[v];
            end
            wbank_r <= ~wbank_r;
            ovf_r   <= ovf_frame_r;
        end
    end

    // Pending start: a start coinciding with the frame end reopens after SWAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= 1'b0;
        end else if (state_r == SWAP) begin
            pend_r <= 1'b0;
        end else if ((state_r == COLLECT) && i_frame_end && i_frame_start) begin
            pend_r <= 1'b1;
        end
    end

    // Frame flag trails the state by one cycle so it falls only once the
    // swapped lengths and bank are already visible to the reader.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            complite_r <= 1'b0;
        end else begin
            complite_r <= (state_r == COLLECT);
        end
    end

    dc_ram #(
        .DW    (DATA_W),
        .ABITS (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (i_wr_data),
        .raddr (raddr_s),
        .rdata (o_rd_data)
    );

    assign o_complite = complite_r;
    assign o_ovf      = ovf_r;
    assign o_data_len = rd_len_r[i_rd_vchn];

`ifdef DATA_COLLECTOR_STATS_EN
    logic [15:0] frame_cnt_r;
    logic [15:0] drop_cur_r;
    logic [15:0] drop_held_r;

    // Frame counter (wrapping) and per-frame saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
            drop_cur_r  <= 16'd0;
            drop_held_r <= 16'd0;
        end else begin
            if (state_r == SWAP) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
                drop_held_r <= drop_cur_r;
            end
            if (frame_open_s) begin
                drop_cur_r <= 16'd0;
            end else if (drop_s && (drop_cur_r != 16'hFFFF)) begin
                drop_cur_r <= drop_cur_r + 16'd1;
            end
        end
    end

    assign o_frame_cnt = frame_cnt_r;
    assign o_drop_cnt  = drop_held_r;
`endif

endmodule

// File: doc/data_collector.md
Name: data_collector

Overview:
- Upstream feeder of the per-group frame reader. One instance per channel group.
- Captures a tagged 32-bit sample stream into 4 virtual-channel buffers and ping-pongs between two banks, so one frame is drained while the next is collected.
- Exports per-channel word count, a 1-cycle-latency read port and the o_complite frame flag; the reader starts draining on the falling edge of o_complite.

Parameters:
- MAX_LEN, 255, max words stored per virtual channel per frame (≤255, fits 8-bit length).
- AW, 8, word address width per channel buffer.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-high.
- i_frame_start  in  1  one-cycle pulse, opens a frame.
- i_frame_end  in  1  one-cycle pulse, closes the frame.
- i_wr_data  in  32  sample word.
- i_wr_vchn  in  2  virtual channel of the sample.
- i_wr_vld  in  1  sample strobe; no back-pressure.
- o_complite  out  1  high while collecting; falls when a new frame becomes readable.
- i_rd_vchn  in  2  read virtual channel.
- i_rd_addr  in  8  read word address.
- o_rd_data  out  32  registered read data.
- o_data_len  out  8  word count of i_rd_vchn in the read bank; combinational.
- o_ovf  out  1  sticky: sample dropped in the last closed frame.

Behaviour:
- Reset: state IDLE; write bank 0, read bank 1; all write and read lengths 0; o_complite=0; o_rd_data=0; o_ovf=0; pending-start flag 0.
- States:
  - IDLE: i_frame_start -> COLLECT.
  - COLLECT: i_frame_end -> SWAP. A repeated i_frame_start restarts the frame: write lengths are zeroed and data is discarded.
  - SWAP: lasts 1 cycle, then -> COLLECT if a start is pending, else -> IDLE.
- Entry to COLLECT: all 4 write lengths cleared; the frame's overflow flag cleared.
- Writes, accepted only in COLLECT with i_wr_vld:
  - If wr_len[vchn] < MAX_LEN: mem[wbank][vchn][wr_len] <= data and wr_len increments.
  - Otherwise the word is dropped and the frame-overflow flag is set.
- A sample arriving in the same cycle as i_frame_end belongs to the closing frame.
- In SWAP: rd_len[0..3] <= wr_len[0..3]; banks toggle; o_ovf <= frame-overflow flag.
- i_frame_start arriving during SWAP is latched as pending. Start and end in the same COLLECT cycle: end wins and start becomes pending.
- o_complite is registered: 1 in COLLECT, 0 in IDLE and SWAP. The falling edge happens on the cycle after the SWAP state (SWAP -> next state registered), so at least 1 low cycle is guaranteed.
- Read:
  - o_rd_data <= mem[rbank][i_rd_vchn][i_rd_addr], valid 1 cycle after the address.
  - Addresses ≥ rd_len return stale data; not an error.
- i_frame_end in IDLE or SWAP is ignored. Writes outside COLLECT are ignored.
- Reset mid-frame: everything returns to reset values immediately; partial frame lost; memory contents undefined.
- Swap is unconditional. Frame period must exceed the reader's drain time; this block provides no protection.

Optional Feature:
- DATA_COLLECTOR_STATS_EN.
  - Defined: adds output o_frame_cnt[15:0], incremented (wrapping) at each SWAP, and o_drop_cnt[15:0], a count of dropped samples in the current frame, saturating at 0xFFFF and copied to a held register at SWAP.
  - Undefined: neither port nor counter exists; o_ovf behaviour unchanged.

Decomposition:
- Shared package dscope_pkg:
  - NUM_VCHN=4, DATA_W=32, LEN_W=8.
  - Collector state enum {IDLE, COLLECT, SWAP}.
- One sub-module dc_ram: simple dual-port, 1 write / 1 registered read, depth 2*4*256, address {bank,vchn,addr}. Infers block RAM.
- FSM, length registers and swap logic stay in data_collector.

Test Plan:
- Reset -> o_complite=0, o_data_len=0 for all vchn, o_rd_data=0, o_ovf=0.
- Start; write 3 words to vchn1 (0xA1,0xA2,0xA3) and 1 word to vchn3 (0xC1); end.
  - Required: o_complite falls.
  - len(vchn1)=3, len(vchn3)=1, others 0.
  - Read vchn1 addr2 -> 0xA3 one cycle later.
- Write 256 words to vchn0 in one frame -> len=255, o_ovf=1 after swap. Next clean frame -> o_ovf=0.
- Frame N is readable while frame N+1 is written with different data -> reads still return frame N until the second end, then frame N+1.
- i_frame_start and i_frame_end in the same cycle -> one SWAP, o_complite low exactly 1 cycle, then new COLLECT with zeroed lengths.
- Assert rst mid-COLLECT after 5 writes -> lengths 0, o_complite=0 asynchronously; a subsequent full frame behaves normally.
